// File: rtl/extend_imm_pkg.sv
// Shared definitions for the decode->issue immediate generator.
// Contents: immediate format codes and the fixed instr[31:7] field width.
package extend_imm_pkg;

    localparam int unsigned IMM_FIELD_W = 25;

    // Format codes 3'b110 and 3'b111 are reserved and flagged as illegal.
    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_J   = 3'd3,
        IMM_U   = 3'd4,
        IMM_CSR = 3'd5
    } imm_type_t;

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: a main register driving the outputs
// plus one skid register that catches the item accepted while main is stalled.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          invalidate both entries; the input item this cycle is dropped
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
module imm_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q;
    logic         skid_valid_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         accept;
    logic         main_free;

    // Ready depends only on skid occupancy, never on out_ready.
    assign in_ready  = !skid_valid_q && !rst;
    assign accept    = in_valid && in_ready;
    // Main can take a new item when empty or when its item leaves this cycle.
    assign main_free = !main_valid_q || out_ready;

    assign out_valid = main_valid_q;
    assign out_data  = main_q;

    // Storage update; flush wins over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else if (flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (main_free) begin
            if (skid_valid_q) begin
                // Older skid item goes first; no accept possible this cycle.
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                main_valid_q <= accept;
                if (accept) begin
                    main_q <= in_data;
                end
            end
        end else if (accept) begin
            skid_q       <= in_data;
            skid_valid_q <= 1'b1;
        end
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered RISC-V immediate generator at the decode->issue boundary.
// Extends instr[31:7] to XLEN per format code, flags reserved codes, and
// carries a side-band tag through a 1-cycle valid/ready skid stage.
// Ports:
//   clk_i, rst_i, flush_i                      clock, sync reset, pipeline flush
//   in_valid_i, in_ready_o                     upstream handshake
//   imm_type_i, imm_i, tag_i                   format code, instr[31:7], tag
//   out_valid_o, out_ready_i                   downstream handshake
//   imm_ext_o, tag_o, illegal_o                extended immediate, tag, reserved-format flag
module imm_extend_pipe
    import extend_imm_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned IMM_WIDTH = 25,
    parameter int unsigned TAG_WIDTH = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [2:0]           imm_type_i,
    input  logic [IMM_WIDTH-1:0] imm_i,
    input  logic [TAG_WIDTH-1:0] tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [XLEN-1:0]      imm_ext_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 illegal_o
);

    localparam int unsigned PAYLOAD_W = 1 + XLEN + TAG_WIDTH;

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_extend_pipe: XLEN must be 32 or 64");
    end
    if (IMM_WIDTH != IMM_FIELD_W) begin : g_bad_imm_width
        $error("imm_extend_pipe: IMM_WIDTH must be 25");
    end

    logic [XLEN-1:0]      imm_ext_c;
    logic                 illegal_c;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    // Format mux; signed casts replicate imm_i[24] up to XLEN.
    always_comb begin
        imm_ext_c = '0;
        illegal_c = 1'b0;
        case (imm_type_i)
            IMM_I:   imm_ext_c = XLEN'($signed(imm_i[24:13]));
            IMM_S:   imm_ext_c = XLEN'($signed({imm_i[24:18], imm_i[4:0]}));
            IMM_B:   imm_ext_c = XLEN'($signed({imm_i[24], imm_i[0], imm_i[23:18],
                                                imm_i[4:1], 1'b0}));
            IMM_J:   imm_ext_c = XLEN'($signed({imm_i[24], imm_i[12:5], imm_i[13],
                                                imm_i[23:14], 1'b0}));
            IMM_U:   imm_ext_c = XLEN'($signed({imm_i[24:5], 12'b0}));
            IMM_CSR: imm_ext_c = XLEN'(imm_i[12:8]);
            default: illegal_c = 1'b1;
        endcase
    end

    assign in_payload = {illegal_c, imm_ext_c, tag_i};

    imm_skid_buf #(
        .W(PAYLOAD_W)
    ) u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (flush_i),
        .in_valid (in_valid_i),
        .in_ready (in_ready_o),
        .in_data  (in_payload),
        .out_valid(out_valid_o),
        .out_ready(out_ready_i),
        .out_data (out_payload)
    );

    assign {illegal_o, imm_ext_o, tag_o} = out_payload;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe (XLEN=64 and XLEN=32 instances
// driven in lockstep), using a capacity-2 FIFO scoreboard and an
// instruction-field reference model.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  imm_type_i;
    logic [24:0] imm_i;
    logic [5:0]  tag_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [63:0] imm_ext_o;
    logic [5:0]  tag_o;
    logic        illegal_o;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] imm32;
    logic [5:0]  tag32;
    logic        ill32;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm;
        logic        ill;
        logic [5:0]  tag;
    } exp_t;

    typedef struct {
        logic [2:0]  typ;
        logic [24:0] imm;
        logic [63:0] exp;
        logic        ill;
    } vec_t;

    exp_t q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(64)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .imm_type_i(imm_type_i), .imm_i(imm_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .imm_ext_o(imm_ext_o), .tag_o(tag_o), .illegal_o(illegal_o)
    );

    imm_extend_pipe #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready32),
        .imm_type_i(imm_type_i), .imm_i(imm_i), .tag_i(tag_i),
        .out_valid_o(out_valid32), .out_ready_i(out_ready_i),
        .imm_ext_o(imm32), .tag_o(tag32), .illegal_o(ill32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: rebuild the 32-bit instruction and decode its immediate fields.
    function automatic void model(input logic [2:0] t, input logic [24:0] f,
                                  output logic [63:0] v, output logic ill);
        logic [31:0] ins;
        longint      x;
        ins = {f, 7'b0};
        x   = longint'(signed'(ins));
        ill = 1'b0;
        v   = '0;
        case (t)
            3'd0: v = 64'(x >>> 20);
            3'd1: v = 64'((x >>> 25) << 5) | 64'(ins[11:7]);
            3'd2: v = 64'((x >>> 31) << 12) | (64'(ins[7]) << 11)
                    | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
            3'd3: v = 64'((x >>> 31) << 20) | (64'(ins[19:12]) << 12)
                    | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
            3'd4: v = 64'(x) & ~64'hFFF;
            3'd5: v = 64'(ins[19:15]);
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic set_item(input logic [5:0] t);
        imm_type_i = 3'($urandom_range(0, 7));
        imm_i      = 25'($urandom);
        tag_i      = t;
    endtask

    // One cycle: inputs already driven at the negedge; check, update model, advance.
    task automatic step(output bit acc, output bit drn, output logic [5:0] otag);
        exp_t        e;
        logic [63:0] ev;
        logic        eill;
        #1;
        acc  = 1'b0;
        drn  = 1'b0;
        otag = tag_o;
        chk("in_ready", 64'(in_ready_o), 64'(!rst_i && q.size() < 2));
        chk("in_ready32", 64'(in_ready32), 64'(!rst_i && q.size() < 2));
        if (rst_i) begin
            q.delete();
        end else begin
            chk("out_valid", 64'(out_valid_o), 64'(q.size() != 0));
            chk("out_valid32", 64'(out_valid32), 64'(q.size() != 0));
            if (flush_i) begin
                q.delete();
            end else begin
                acc = in_valid_i && in_ready_o;
                drn = out_valid_o && out_ready_i;
                if (drn && q.size() != 0) begin
                    e = q.pop_front();
                    chk("imm64", imm_ext_o, e.imm);
                    chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
                    chk("illegal", 64'(illegal_o), 64'(e.ill));
                    chk("illegal32", 64'(ill32), 64'(e.ill));
                    chk("tag", 64'(tag_o), 64'(e.tag));
                    chk("tag32", 64'(tag32), 64'(e.tag));
                end
                if (acc) begin
                    model(imm_type_i, imm_i, ev, eill);
                    e.imm = ev;
                    e.ill = eill;
                    e.tag = tag_i;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t        vecs[10];
        bit          a;
        bit          d;
        logic [5:0]  t;
        logic [5:0]  got[$];
        int          nxt;
        bit          pend;

        vecs[0] = '{3'd0, 25'h1FFE001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1] = '{3'd4, 25'h1000000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[2] = '{3'd5, 25'h1001F00, 64'h0000_0000_0000_001F, 1'b0};
        vecs[3] = '{3'd6, 25'h1FFFFFF, 64'h0, 1'b1};
        vecs[4] = '{3'd7, 25'h0ABCDEF, 64'h0, 1'b1};
        vecs[5] = '{3'd1, 25'h0FC0018, 64'h0000_0000_0000_07F8, 1'b0};
        vecs[6] = '{3'd2, 25'h1FC001F, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
        vecs[7] = '{3'd3, 25'h0002000, 64'h0000_0000_0000_0800, 1'b0};
        vecs[8] = '{3'd3, 25'h0000020, 64'h0000_0000_0000_1000, 1'b0};
        vecs[9] = '{3'd0, 25'h0FFE000, 64'h0000_0000_0000_07FF, 1'b0};

        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        imm_type_i = '0; imm_i = '0; tag_i = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) step(a, d, t);
        rst_i = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_imm", imm_ext_o, 64'h0);
        chk("rst_tag", 64'(tag_o), 64'(0));
        chk("rst_illegal", 64'(illegal_o), 64'(0));
        chk("rst_imm32", 64'(imm32), 64'(0));
        chk("rst_in_ready", 64'(in_ready_o), 64'(1));

        // Directed format table at full throughput, latency 1.
        out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid_i = 1'b1;
            imm_type_i = vecs[i].typ;
            imm_i      = vecs[i].imm;
            tag_i      = 6'(i + 1);
            step(a, d, t);
            chk("vec_valid", 64'(out_valid_o), 64'(1));
            chk("vec_imm64", imm_ext_o, vecs[i].exp);
            chk("vec_imm32", 64'(imm32), 64'(vecs[i].exp[31:0]));
            chk("vec_illegal", 64'(illegal_o), 64'(vecs[i].ill));
            chk("vec_tag", 64'(tag_o), 64'(i + 1));
        end
        in_valid_i = 1'b0;
        step(a, d, t);

        // Back-pressure: tags 1..4, downstream stalled for 3 cycles.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        set_item(6'd1);
        step(a, d, t);
        chk("bp_acc1", 64'(a), 64'(1));
        set_item(6'd2);
        step(a, d, t);
        chk("bp_acc2", 64'(a), 64'(1));
        chk("bp_in_ready_low", 64'(in_ready_o), 64'(0));
        set_item(6'd3);
        step(a, d, t);
        chk("bp_acc3_blocked", 64'(a), 64'(0));
        out_ready_i = 1'b1;
        nxt = 3;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            in_valid_i = (nxt <= 4);
            step(a, d, t);
            if (d) got.push_back(t);
            if (a) begin
                nxt++;
                if (nxt <= 4) set_item(6'(nxt));
            end
        end
        in_valid_i = 1'b0;
        chk("bp_count", 64'(got.size()), 64'(4));
        for (int i = 0; i < got.size() && i < 4; i++) chk("bp_order", 64'(got[i]), 64'(i + 1));

        // Flush with main and skid full and an input offered.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        set_item(6'd10);
        step(a, d, t);
        set_item(6'd11);
        step(a, d, t);
        chk("fl_full", 64'(in_ready_o), 64'(0));
        flush_i = 1'b1;
        set_item(6'd12);
        step(a, d, t);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("fl_out_valid", 64'(out_valid_o), 64'(0));
        chk("fl_in_ready", 64'(in_ready_o), 64'(1));
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        set_item(6'd13);
        step(a, d, t);
        in_valid_i = 1'b0;
        chk("fl_next_valid", 64'(out_valid_o), 64'(1));
        chk("fl_next_tag", 64'(tag_o), 64'(13));
        step(a, d, t);

        // Reset pulsed mid-stream.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        set_item(6'd20);
        step(a, d, t);
        set_item(6'd21);
        step(a, d, t);
        rst_i = 1'b1;
        step(a, d, t);
        chk("mr_out_valid", 64'(out_valid_o), 64'(0));
        chk("mr_imm", imm_ext_o, 64'h0);
        chk("mr_tag", 64'(tag_o), 64'(0));
        chk("mr_illegal", 64'(illegal_o), 64'(0));
        chk("mr_in_ready", 64'(in_ready_o), 64'(0));
        step(a, d, t);
        rst_i      = 1'b0;
        in_valid_i = 1'b0;
        #1;
        chk("mr_in_ready_after", 64'(in_ready_o), 64'(1));
        step(a, d, t);

        // Random traffic with holds, flushes and resets.
        pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_i   = ($urandom_range(0, 199) == 0);
            flush_i = !rst_i && ($urandom_range(0, 49) == 0);
            if (!pend) begin
                in_valid_i = ($urandom_range(0, 9) < 7);
                if (in_valid_i) set_item(6'($urandom));
            end
            out_ready_i = ($urandom_range(0, 9) < 6);
            step(a, d, t);
            pend = in_valid_i && !a && !rst_i && !flush_i;
        end

        rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) step(a, d, t);
        chk("drain_empty", 64'(q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
